// File: rtl/mux2x1_structural_if.sv
// Signal bundle for mux2x1_structural: data/select/enable toward the mux,
// combinational and registered results back out.
interface mux2x1_structural_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             y_vld;

  // The master steers the mux and consumes its results; the mux itself is the slave.
  modport master (
    output a, b, sel, en,
    input  y, y_q, y_vld
  );

  modport slave (
    input  a, b, sel, en,
    output y, y_q, y_vld
  );
endinterface

// File: rtl/mux2x1_structural.sv
// Gate-level 2:1 word multiplexer with a clock-enabled output register.
// WIDTH must match the WIDTH of the connected mux2x1_structural_if.
module mux2x1_structural #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux2x1_structural_if.slave   bus
);

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             sel_in;
  logic             sel_n;
  logic [WIDTH-1:0] y_int;
  logic [WIDTH-1:0] y_reg;
  logic             vld_reg;

  assign a_in   = bus.a;
  assign b_in   = bus.b;
  assign sel_in = bus.sel;

  // One inverter on sel is shared by every bit slice.
  not u_sel_inv (sel_n, sel_in);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic a_term;
    logic b_term;

    and u_and_a (a_term,   a_in[i], sel_n);
    and u_and_b (b_term,   b_in[i], sel_in);
    or  u_or    (y_int[i], a_term,  b_term);
  end

  // y_vld marks that y_q holds a real capture rather than the reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg   <= RST_VAL;
      vld_reg <= 1'b0;
    end else if (bus.en) begin
      y_reg   <= y_int;
      vld_reg <= 1'b1;
    end
  end

  assign bus.y     = y_int;
  assign bus.y_q   = y_reg;
  assign bus.y_vld = vld_reg;

endmodule

// File: tb/tb_mux2x1_structural.sv
// Scoreboard bench for mux2x1_structural: a 1-bit and an 8-bit instance share
// clock and reset; stimulus queues expectations, a monitor pops and compares.
module tb_mux2x1_structural;

  typedef struct {
    string      name;
    int         dut_id;
    bit         chk_y;
    logic [7:0] exp_y;
    bit         chk_reg;
    logic [7:0] exp_q;
    logic       exp_vld;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  logic sample_stb;

  int n_vec;
  int n_miss;
  sb_entry_t sb[$];

  mux2x1_structural_if #(.WIDTH(1)) if1 ();
  mux2x1_structural_if #(.WIDTH(8)) if8 ();

  mux2x1_structural #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  mux2x1_structural #(.WIDTH(8), .RST_VAL(8'h5A)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: every strobe drains the queued expectations against the live outputs.
  initial begin
    sb_entry_t  e;
    logic [7:0] got_y;
    logic [7:0] got_q;
    logic       got_v;
    forever begin
      @(posedge sample_stb);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.dut_id == 1) begin
          got_y = {7'b0, if1.y};
          got_q = {7'b0, if1.y_q};
          got_v = if1.y_vld;
        end else begin
          got_y = if8.y;
          got_q = if8.y_q;
          got_v = if8.y_vld;
        end
        if (e.chk_y) begin
          n_vec++;
          if (got_y !== e.exp_y) begin
            n_miss++;
            $display("[TB] FAIL %s y: got %h want %h", e.name, got_y, e.exp_y);
          end
        end
        if (e.chk_reg) begin
          n_vec++;
          if (got_q !== e.exp_q) begin
            n_miss++;
            $display("[TB] FAIL %s y_q: got %h want %h", e.name, got_q, e.exp_q);
          end
          n_vec++;
          if (got_v !== e.exp_vld) begin
            n_miss++;
            $display("[TB] FAIL %s y_vld: got %b want %b", e.name, got_v, e.exp_vld);
          end
        end
      end
    end
  end

  task automatic check_output(input string nm, input int id,
                              input bit cy, input logic [7:0] ey,
                              input bit cr, input logic [7:0] eq, input logic ev);
    sb_entry_t e;
    e.name    = nm;
    e.dut_id  = id;
    e.chk_y   = cy;
    e.exp_y   = ey;
    e.chk_reg = cr;
    e.exp_q   = eq;
    e.exp_vld = ev;
    sb.push_back(e);
    sample_stb = 1'b1;
    #1;
    sample_stb = 1'b0;
  endtask

  task automatic apply_stimulus(input int id, input logic [7:0] va, input logic [7:0] vb,
                                input logic vs, input logic ve);
    if (id == 1) begin
      if1.a   = va[0];
      if1.b   = vb[0];
      if1.sel = vs;
      if1.en  = ve;
    end else begin
      if8.a   = va;
      if8.b   = vb;
      if8.sel = vs;
      if8.en  = ve;
    end
  endtask

  // Hand-computed truth table rows: {a, b, sel, expected y}.
  logic [3:0] truth [8] = '{4'b0000, 4'b0100, 4'b0111, 4'b1001,
                            4'b1010, 4'b1101, 4'b1111, 4'b0010};

  initial begin
    logic [7:0] model_q;
    logic       model_v;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    logic       re;
    logic [3:0] row;

    n_vec      = 0;
    n_miss     = 0;
    sample_stb = 1'b0;
    rst_n      = 1'b0;
    apply_stimulus(1, 8'h00, 8'h00, 1'b0, 1'b0);
    apply_stimulus(8, 8'h00, 8'h00, 1'b0, 1'b0);

    #3;
    check_output("reset_w1", 1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    check_output("reset_w8", 8, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      row = truth[i];
      apply_stimulus(1, {7'b0, row[3]}, {7'b0, row[2]}, row[1], 1'b0);
      #1;
      check_output($sformatf("truth_%0d%0d%0d", row[3], row[2], row[1]), 1,
                   1'b1, {7'b0, row[0]}, 1'b0, 8'h00, 1'b0);
      #8;
    end

    apply_stimulus(8, 8'hA5, 8'h3C, 1'b0, 1'b0);
    #1;
    check_output("w8_sel0", 8, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    if8.sel = 1'b1;
    #1;
    check_output("w8_sel1", 8, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #5;
      if8.sel = ~if8.sel;
      #1;
      check_output("w8_toggle", 8, 1'b1, if8.sel ? 8'h3C : 8'hA5, 1'b0, 8'h00, 1'b0);
    end

    @(negedge clk);
    apply_stimulus(1, 8'h01, 8'h00, 1'b0, 1'b1);
    check_output("w1_preload", 1, 1'b1, 8'h01, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    if1.en  = 1'b0;
    if1.sel = 1'b1;
    check_output("w1_loaded", 1, 1'b1, 8'h00, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("w1_hold", 1, 1'b1, 8'h00, 1'b1, 8'h01, 1'b1);
    end

    @(negedge clk);
    apply_stimulus(8, 8'hFF, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check_output("w8_loadff", 8, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("w8_async_rst", 8, 1'b1, 8'hFF, 1'b1, 8'h5A, 1'b0);
    @(negedge clk);
    check_output("w8_rst_en_ignored", 8, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);

    apply_stimulus(8, 8'h12, 8'h77, 1'b0, 1'b1);
    #1;
    rst_n = 1'b1;
    check_output("w8_release_before", 8, 1'b1, 8'h12, 1'b1, 8'h5A, 1'b0);
    @(posedge clk);
    #1;
    check_output("w8_release_after", 8, 1'b1, 8'h12, 1'b1, 8'h12, 1'b1);

    model_q = 8'h12;
    model_v = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check_output("rand_reg", 8, 1'b0, 8'h00, 1'b1, model_q, model_v);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      re = 1'($urandom);
      apply_stimulus(8, ra, rb, rs, re);
      #1;
      check_output("rand_y", 8, 1'b1, rs ? rb : ra, 1'b0, 8'h00, 1'b0);
      if (re) begin
        model_q = rs ? rb : ra;
        model_v = 1'b1;
      end
    end
    @(negedge clk);
    check_output("rand_final", 8, 1'b0, 8'h00, 1'b1, model_q, model_v);

    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
